// File: rtl/pcie_wdma_pkg.sv
// Shared types and constants for the CC-sniffer write-DMA ring sequencer.
package pcie_wdma_pkg;

  localparam int unsigned DESC_FRAMES_W = 16;

  localparam logic [5:0] OH_IDLE    = 6'b000001;
  localparam logic [5:0] OH_LOAD    = 6'b000010;
  localparam logic [5:0] OH_WAIT    = 6'b000100;
  localparam logic [5:0] OH_DMA     = 6'b001000;
  localparam logic [5:0] OH_CHECK   = 6'b010000;
  localparam logic [5:0] OH_STOPPED = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE    = OH_IDLE,
    S_LOAD    = OH_LOAD,
    S_WAIT    = OH_WAIT,
    S_DMA     = OH_DMA,
    S_CHECK   = OH_CHECK,
    S_STOPPED = OH_STOPPED
  } state_t;

  localparam logic [3:0] ST_NEXT        = 4'b0001;
  localparam logic [3:0] ST_EMPTY_START = 4'b0010;
  localparam logic [3:0] ST_EMPTY_DONE  = 4'b0011;
  localparam logic [3:0] ST_STOP        = 4'b0100;
  localparam logic [3:0] ST_TMO         = 4'b1000;

  function automatic int unsigned desc_w(input int unsigned addr_w);
    return addr_w + DESC_FRAMES_W;
  endfunction

  // Bytes per frame: 4 * len_dw * tlp_count, kept to 32 bits.
  function automatic logic [31:0] frame_bytes(input logic [9:0] len, input logic [15:0] cnt);
    logic [31:0] prod;
    prod = {22'd0, len} * {16'd0, cnt};
    return {prod[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/pcie_wdma_ring_fsm_if.sv
// Descriptor-push and DMA-engine signal bundle of the write-DMA sequencer.
interface pcie_wdma_ring_fsm_if #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DESC_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DESC_DEPTH) + 1;

  logic [ADDR_W-1:0] desc_addr_i;
  logic [15:0]       desc_frames_i;
  logic              desc_push_i;
  logic              desc_full_o;
  logic [LVL_W-1:0]  desc_level_o;
  logic [9:0]        mwr_len_i;
  logic [15:0]       mwr_count_i;
  logic              dma_start_o;
  logic [ADDR_W-1:0] dma_addr_o;
  logic              dma_done_i;
  logic              dma_rst_o;

  // Sequencer side
  modport master (
    input  desc_addr_i, desc_frames_i, desc_push_i, mwr_len_i, mwr_count_i, dma_done_i,
    output desc_full_o, desc_level_o, dma_start_o, dma_addr_o, dma_rst_o
  );

  // Register file / engine side
  modport slave (
    output desc_addr_i, desc_frames_i, desc_push_i, mwr_len_i, mwr_count_i, dma_done_i,
    input  desc_full_o, desc_level_o, dma_start_o, dma_addr_o, dma_rst_o
  );
endinterface

// File: rtl/pcie_wdma_desc_fifo.sv
// Synchronous descriptor FIFO {frames, addr} with level, full and empty.
module pcie_wdma_desc_fifo #(
  parameter  int unsigned W     = 80,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || srst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/pcie_wdma_ring_fsm.sv
// Write-DMA ring sequencer: descriptor queue feeding per-frame DMAs to the BMD TX engine.
// Optional feature: define PCIE_WDMA_DROP_CNT_EN to add the missed-frame counter drop_cnt_o.
module pcie_wdma_ring_fsm
  import pcie_wdma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned TMO_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_rst_i,
  pcie_wdma_ring_fsm_if.master bus,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 frame_end_i,
  output logic                 irq_o,
  output logic [3:0]           status_o,
  output logic                 running_o,
  output logic [15:0]          buf_ptr_o,
  output logic                 timeout_o
`ifdef PCIE_WDMA_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt_o
`endif
);
  localparam int unsigned DW    = desc_w(ADDR_W);
  localparam int unsigned LVL_W = $clog2(DESC_DEPTH) + 1;

  state_t            state_r, state_nx_s;
  logic              rst_s;
  logic              fe_q_r;
  logic              stop_r;
  logic              stop_any_s;
  logic              after_chk_r, after_chk_nx_s;
  logic              dma_start_r, dma_start_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic [15:0]       cur_frames_r, frames_nx_s;
  logic              irq_r, irq_nx_s;
  logic [3:0]        status_r, status_nx_s;
  logic              running_r, running_nx_s;
  logic [15:0]       buf_ptr_r, buf_ptr_nx_s;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic [DW-1:0]     fifo_rd_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [15:0]       rd_frames_s;
  logic [ADDR_W-1:0] size_s;

  assign rst_s       = !rst_n || init_rst_i;
  assign stop_any_s  = stop_r || stop_i;
  assign rd_addr_s   = fifo_rd_s[ADDR_W-1:0];
  assign rd_frames_s = fifo_rd_s[DW-1:ADDR_W];
  assign size_s      = {{(ADDR_W-32){1'b0}}, frame_bytes(bus.mwr_len_i, bus.mwr_count_i)};

  // Zero-length descriptors never enter the queue.
  pcie_wdma_desc_fifo #(.W(DW), .DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (init_rst_i),
    .push  (bus.desc_push_i && (bus.desc_frames_i != 16'd0)),
    .wdata ({bus.desc_frames_i, bus.desc_addr_i}),
    .pop   (pop_s),
    .rdata (fifo_rd_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.desc_full_o  = fifo_full_s;
  assign bus.desc_level_o = fifo_level_s;
  assign bus.dma_start_o  = dma_start_r;
  assign bus.dma_addr_o   = addr_r;
  assign bus.dma_rst_o    = frame_end_i && (state_r == S_WAIT);
  assign irq_o            = irq_r;
  assign status_o         = status_r;
  assign running_o        = running_r;
  assign buf_ptr_o        = buf_ptr_r;
  assign timeout_o        = tmo_cnt_r[TMO_W-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nx_s     = state_r;
    pop_s          = 1'b0;
    dma_start_nx_s = dma_start_r;
    addr_nx_s      = addr_r;
    frames_nx_s    = cur_frames_r;
    irq_nx_s       = 1'b0;
    status_nx_s    = status_r;
    running_nx_s   = running_r;
    buf_ptr_nx_s   = buf_ptr_r;
    after_chk_nx_s = after_chk_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          after_chk_nx_s = 1'b0;
          state_nx_s     = S_LOAD;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LOAD: begin
        buf_ptr_nx_s = 16'd0;
        if (!fifo_empty_s && !stop_any_s) begin
          pop_s        = 1'b1;
          addr_nx_s    = rd_addr_s;
          frames_nx_s  = rd_frames_s;
          running_nx_s = 1'b1;
          state_nx_s   = S_WAIT;
        end else begin
          running_nx_s = 1'b0;
          state_nx_s   = S_STOPPED;
          // A buffer-full IRQ from CHECK already reported the empty queue.
          if (fifo_empty_s && !after_chk_r) begin
            irq_nx_s    = 1'b1;
            status_nx_s = ST_EMPTY_START;
          end else begin
            irq_nx_s = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (tmo_cnt_r[TMO_W-1]) begin
          irq_nx_s     = 1'b1;
          status_nx_s  = ST_TMO;
          running_nx_s = 1'b0;
          state_nx_s   = S_STOPPED;
        end else if (fe_q_r) begin
          dma_start_nx_s = 1'b1;
          state_nx_s     = S_DMA;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_DMA: begin
        if (bus.dma_done_i) begin
          dma_start_nx_s = 1'b0;
          addr_nx_s      = addr_r + size_s;
          buf_ptr_nx_s   = buf_ptr_r + 16'd1;
          state_nx_s     = S_CHECK;
        end else begin
          state_nx_s = S_DMA;
        end
      end
      S_CHECK: begin
        if (stop_any_s) begin
          irq_nx_s     = 1'b1;
          status_nx_s  = ST_STOP;
          running_nx_s = 1'b0;
          state_nx_s   = S_STOPPED;
        end else if (buf_ptr_r == cur_frames_r) begin
          irq_nx_s       = 1'b1;
          status_nx_s    = fifo_empty_s ? ST_EMPTY_DONE : ST_NEXT;
          after_chk_nx_s = 1'b1;
          state_nx_s     = S_LOAD;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_STOPPED: begin
        running_nx_s = 1'b0;
        state_nx_s   = S_STOPPED;
      end
      default: begin
        running_nx_s   = 1'b0;
        dma_start_nx_s = 1'b0;
        state_nx_s     = S_IDLE;
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      dma_start_r  <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      cur_frames_r <= 16'd0;
      irq_r        <= 1'b0;
      status_r     <= 4'd0;
      running_r    <= 1'b0;
      buf_ptr_r    <= 16'd0;
      after_chk_r  <= 1'b0;
      fe_q_r       <= 1'b0;
    end else begin
      dma_start_r  <= dma_start_nx_s;
      addr_r       <= addr_nx_s;
      cur_frames_r <= frames_nx_s;
      irq_r        <= irq_nx_s;
      status_r     <= status_nx_s;
      running_r    <= running_nx_s;
      buf_ptr_r    <= buf_ptr_nx_s;
      after_chk_r  <= after_chk_nx_s;
      fe_q_r       <= frame_end_i;
    end
  end

  // Sticky stop request, consumed once STOPPED is reached.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      stop_r <= 1'b0;
    end else if (state_r == S_STOPPED) begin
      stop_r <= 1'b0;
    end else if (stop_i) begin
      stop_r <= 1'b1;
    end else begin
      stop_r <= stop_r;
    end
  end

  // CC timeout: counts WAIT_FRAME cycles since the last frame end, saturating at the MSB.
  always_ff @(posedge clk) begin
    if (rst_s || frame_end_i) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == S_WAIT) && !tmo_cnt_r[TMO_W-1]) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

`ifdef PCIE_WDMA_DROP_CNT_EN
  logic [15:0] drop_cnt_r;

  // Frame ends arriving while a DMA is in flight or being checked are missed frames.
  always_ff @(posedge clk) begin
    if (rst_s || (state_r == S_LOAD)) begin
      drop_cnt_r <= 16'd0;
    end else if (frame_end_i && ((state_r == S_DMA) || (state_r == S_CHECK)) &&
                 (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_pcie_wdma_ring_fsm.sv
// Scoreboard bench for pcie_wdma_ring_fsm; the missed-frame test needs PCIE_WDMA_DROP_CNT_EN.
module tb_pcie_wdma_ring_fsm;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DESC_DEPTH = 4;
  localparam int unsigned TMO_W      = 10;

  logic        clk = 1'b0;
  logic        rst_n, init_rst_i, start_i, stop_i, frame_end_i;
  logic        irq_o, running_o, timeout_o;
  logic [3:0]  status_o;
  logic [15:0] buf_ptr_o;
`ifdef PCIE_WDMA_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
`endif

  pcie_wdma_ring_fsm_if #(.ADDR_W(ADDR_W), .DESC_DEPTH(DESC_DEPTH)) bus ();

  pcie_wdma_ring_fsm #(.ADDR_W(ADDR_W), .DESC_DEPTH(DESC_DEPTH), .TMO_W(TMO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_rst_i  (init_rst_i),
    .bus         (bus),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .frame_end_i (frame_end_i),
    .irq_o       (irq_o),
    .status_o    (status_o),
    .running_o   (running_o),
    .buf_ptr_o   (buf_ptr_o),
    .timeout_o   (timeout_o)
`ifdef PCIE_WDMA_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] ptr;
  } exp_dma_t;

  exp_dma_t    exp_dma_q[$];
  logic [3:0]  exp_irq_q[$];
  logic [63:0] stim_addr_q[$];
  logic [15:0] stim_frm_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        eng_hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dma_start"}, 64'(bus.dma_start_o), 64'd0);
    chk({tag, "_dma_addr"},  bus.dma_addr_o, 64'd0);
    chk({tag, "_irq"},       64'(irq_o), 64'd0);
    chk({tag, "_status"},    64'(status_o), 64'd0);
    chk({tag, "_running"},   64'(running_o), 64'd0);
    chk({tag, "_buf_ptr"},   64'(buf_ptr_o), 64'd0);
    chk({tag, "_timeout"},   64'(timeout_o), 64'd0);
    chk({tag, "_full"},      64'(bus.desc_full_o), 64'd0);
    chk({tag, "_level"},     64'(bus.desc_level_o), 64'd0);
`ifdef PCIE_WDMA_DROP_CNT_EN
    chk({tag, "_drop_cnt"},  64'(drop_cnt_o), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; frame_end_i = 1'b0;
    bus.desc_push_i = 1'b0; bus.desc_addr_i = 64'd0; bus.desc_frames_i = 16'd0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_zero("reset");
  endtask

  task automatic push_desc(input logic [63:0] a, input logic [15:0] f);
    bus.desc_addr_i = a; bus.desc_frames_i = f; bus.desc_push_i = 1'b1;
    tick(1);
    bus.desc_push_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic fe_pulse(input logic exp_rst);
    frame_end_i = 1'b1;
    #1;
    chk("dma_rst", 64'(bus.dma_rst_o), 64'(exp_rst));
    @(negedge clk);
    frame_end_i = 1'b0;
  endtask

  task automatic wait_start(input logic lvl, input string nm);
    int n = 0;
    while (bus.dma_start_o !== lvl && n < 64) begin
      tick(1);
      n++;
    end
    chk(nm, 64'(bus.dma_start_o), 64'(lvl));
  endtask

  task automatic frame_cycle();
    tick(3 + int'($urandom_range(0, 2)));
    fe_pulse(1'b1);
    wait_start(1'b1, "dma_start_rise");
    wait_start(1'b0, "dma_start_fall");
  endtask

  // Model: accepted descriptors are the first DESC_DEPTH non-zero pushes, served in order.
  task automatic run_stim(input logic [9:0] len, input logic [15:0] cnt,
                          input bit late_push, input logic [63:0] late_addr);
    logic [63:0] acc_addr[$];
    logic [15:0] acc_frm[$];
    logic [63:0] sz;
    exp_dma_t    e;
    int          total = 0;
    int          n_before;
    do_reset();
    bus.mwr_len_i = len; bus.mwr_count_i = cnt;
    sz = 64'(len) * 64'(cnt) * 64'd4;
    foreach (stim_addr_q[i]) begin
      push_desc(stim_addr_q[i], stim_frm_q[i]);
      if (stim_frm_q[i] != 16'd0 && acc_addr.size() < DESC_DEPTH) begin
        acc_addr.push_back(stim_addr_q[i]);
        acc_frm.push_back(stim_frm_q[i]);
      end
    end
    tick(1);
    chk("level", 64'(bus.desc_level_o), 64'(acc_addr.size()));
    chk("full", 64'(bus.desc_full_o), 64'(acc_addr.size() == DESC_DEPTH));
    n_before = acc_addr.size();
    if (late_push && acc_addr.size() < DESC_DEPTH) begin
      acc_addr.push_back(late_addr);
      acc_frm.push_back(16'd1);
    end
    foreach (acc_addr[k]) begin
      for (int f = 0; f < int'(acc_frm[k]); f++) begin
        e.addr = acc_addr[k] + sz * 64'(f);
        e.ptr  = 16'(f);
        exp_dma_q.push_back(e);
        total++;
      end
      exp_irq_q.push_back((k == acc_addr.size() - 1) ? 4'b0011 : 4'b0001);
    end
    if (acc_addr.size() == 0) exp_irq_q.push_back(4'b0010);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    if (late_push) begin
      bus.desc_addr_i = late_addr; bus.desc_frames_i = 16'd1; bus.desc_push_i = 1'b1;
      tick(1);
      bus.desc_push_i = 1'b0;
      chk("level_push_pop", 64'(bus.desc_level_o),
          64'((n_before < DESC_DEPTH) ? n_before : n_before - 1));
    end
    for (int i = 0; i < total; i++) frame_cycle();
    tick(8);
    chk("end_running", 64'(running_o), 64'd0);
    chk("end_level", 64'(bus.desc_level_o), 64'd0);
    chk("dma_q_drained", 64'(exp_dma_q.size()), 64'd0);
    chk("irq_q_drained", 64'(exp_irq_q.size()), 64'd0);
  endtask

  // Engine model: completes each frame DMA after a random delay.
  initial begin : engine
    bus.dma_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_start_o && !eng_hold) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        bus.dma_done_i = 1'b1;
        @(negedge clk);
        bus.dma_done_i = 1'b0;
        @(negedge clk);
      end
    end
  end

  // Scoreboard monitor: pops expectations on each DMA start edge and each IRQ.
  initial begin : monitor
    logic     prev_start;
    exp_dma_t e;
    logic [3:0] s;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_start_o && !prev_start) begin
        if (exp_dma_q.size() == 0) begin
          chk("dma_unexpected_start", 64'(bus.dma_start_o), 64'd0);
        end else begin
          e = exp_dma_q.pop_front();
          chk("dma_addr", bus.dma_addr_o, e.addr);
          chk("dma_buf_ptr", 64'(buf_ptr_o), 64'(e.ptr));
        end
      end
      if (irq_o) begin
        if (exp_irq_q.size() == 0) begin
          chk("irq_unexpected", 64'(irq_o), 64'd0);
        end else begin
          s = exp_irq_q.pop_front();
          chk("irq_status", 64'(status_o), 64'(s));
        end
      end
      prev_start = bus.dma_start_o;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    exp_dma_t e;
    int n;
    bus.mwr_len_i = 10'd32; bus.mwr_count_i = 16'd16;

    // Two buffers, 3 frames total.
    stim_addr_q = '{64'h1_0000_0000, 64'h2000};
    stim_frm_q  = '{16'd2, 16'd1};
    run_stim(10'd32, 16'd16, 1'b0, 64'd0);

    // Empty queue at start.
    do_reset();
    exp_irq_q.push_back(4'b0010);
    pulse_start();
    tick(6);
    chk("empty_running", 64'(running_o), 64'd0);
    chk("irq_q_drained_empty", 64'(exp_irq_q.size()), 64'd0);

    // Timeout in WAIT_FRAME.
    do_reset();
    bus.mwr_len_i = 10'd1; bus.mwr_count_i = 16'd1;
    push_desc(64'h8000, 16'd2);
    e.addr = 64'h8000; e.ptr = 16'd0; exp_dma_q.push_back(e);
    exp_irq_q.push_back(4'b1000);
    pulse_start();
    frame_cycle();
    tick(100);
    chk("tmo_early", 64'(timeout_o), 64'd0);
    n = 0;
    while (running_o && n < 2000) begin tick(1); n++; end
    tick(2);
    chk("tmo_running", 64'(running_o), 64'd0);
    chk("tmo_flag", 64'(timeout_o), 64'd1);
    chk("irq_q_drained_tmo", 64'(exp_irq_q.size()), 64'd0);

    // Stop during DMA.
    do_reset();
    bus.mwr_len_i = 10'd8; bus.mwr_count_i = 16'd2;
    push_desc(64'h10_0000, 16'd3);
    e.addr = 64'h10_0000; e.ptr = 16'd0; exp_dma_q.push_back(e);
    exp_irq_q.push_back(4'b0100);
    pulse_start();
    tick(3);
    fe_pulse(1'b1);
    wait_start(1'b1, "stop_dma_rise");
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    wait_start(1'b0, "stop_dma_fall");
    tick(6);
    chk("stop_buf_ptr", 64'(buf_ptr_o), 64'd1);
    chk("stop_running", 64'(running_o), 64'd0);
    pulse_start();
    tick(3);
    fe_pulse(1'b0);
    tick(6);
    chk("stopped_sticky", 64'(running_o), 64'd0);
    chk("stop_drained", 64'(exp_irq_q.size() + exp_dma_q.size()), 64'd0);

    // DESC_DEPTH+1 pushes: last one ignored.
    stim_addr_q = '{64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h5000};
    stim_frm_q  = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    run_stim(10'd4, 16'd4, 1'b0, 64'd0);

    // Push and pop in the same cycle.
    stim_addr_q = '{64'hA000, 64'hB000};
    stim_frm_q  = '{16'd1, 16'd1};
    run_stim(10'd2, 16'd3, 1'b1, 64'hC000);

    // Randomized buffers, including zero-length descriptors and address wrap.
    for (int it = 0; it < 6; it++) begin
      stim_addr_q.delete();
      stim_frm_q.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        stim_addr_q.push_back((it == 0 && i == 0) ? 64'hFFFF_FFFF_FFFF_F000 : {$urandom, $urandom});
        stim_frm_q.push_back(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 3)));
      end
      run_stim(10'($urandom_range(1, 1023)), 16'($urandom_range(1, 65535)), 1'b0, 64'd0);
    end

`ifdef PCIE_WDMA_DROP_CNT_EN
    // Missed frames during one DMA, then soft reset mid-DMA.
    do_reset();
    bus.mwr_len_i = 10'd32; bus.mwr_count_i = 16'd16;
    push_desc(64'h4000, 16'd2);
    e.addr = 64'h4000; e.ptr = 16'd0; exp_dma_q.push_back(e);
    eng_hold = 1'b1;
    pulse_start();
    tick(3);
    fe_pulse(1'b1);
    wait_start(1'b1, "drop_dma_rise");
    for (int i = 0; i < 3; i++) begin
      fe_pulse(1'b0);
      tick(1);
    end
    chk("drop_cnt", 64'(drop_cnt_o), 64'd3);
    init_rst_i = 1'b1;
    tick(1);
    init_rst_i = 1'b0;
    check_zero("init_rst");
    eng_hold = 1'b0;
    tick(4);
    chk("drop_drained", 64'(exp_dma_q.size() + exp_irq_q.size()), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
